// File: rtl/arith_codec_pkg.sv
// Shared definitions for the arithmetic codec output path: ack FSM states,
// word geometry and the byte bit-reversal helper.
package arith_codec_pkg;

  localparam int CODEC_WORD_WIDTH = 32;
  localparam int WORD_BYTES       = CODEC_WORD_WIDTH / 8;
  localparam int NBYTES_W         = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    A_IDLE,
    A_ACK,
    A_REL
  } ack_state_e;

  function automatic logic [7:0] reverse_byte(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/arith_byte_unpacker.sv
// Output register O: holds one word, shifts it out one byte per accepted
// transfer on a byte-wide AXI-Stream and counts bytes of the current stream.
module arith_byte_unpacker
  import arith_codec_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int BIT_REVERSE = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic [NBYTES_W-1:0]   load_nbytes,
  input  logic                  load_last,
  output logic                  empty,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  byte_count
);

  logic [WORD_WIDTH-1:0] word_q;
  logic [NBYTES_W-1:0]   rem_q;
  logic                  last_q;
  logic                  clear_q;
  logic                  fire;

  assign m_tvalid = (rem_q != '0);
  assign empty    = ~m_tvalid;
  assign fire     = m_tvalid & m_tready;
  assign m_tlast  = last_q & (rem_q == NBYTES_W'(1));
  assign m_tdata  = (BIT_REVERSE != 0) ? reverse_byte(word_q[7:0]) : word_q[7:0];

  // The current byte always sits in the low lane; shifting keeps the mux trivial.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      word_q <= load_data;
      rem_q  <= load_nbytes;
      last_q <= load_last;
    end else if (fire) begin
      word_q <= word_q >> 8;
      rem_q  <= rem_q - NBYTES_W'(1);
    end
  end

  // The count shows the full stream length for one cycle after the tlast transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_count <= '0;
      clear_q    <= 1'b0;
    end else begin
      clear_q <= fire & m_tlast;
      if (fire) begin
        byte_count <= (clear_q ? {CNT_WIDTH{1'b0}} : byte_count) + CNT_WIDTH'(1);
      end else if (clear_q) begin
        byte_count <= '0;
      end
    end
  end

endmodule

// File: rtl/arithmetic_output_serializer.sv
// Encoder-facing side: resultReady/readSuccess handshake, one-word hold register
// and the final/non-final decision that feeds the byte unpacker.
module arithmetic_output_serializer
  import arith_codec_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int BIT_REVERSE = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enc_result_ready,
  input  logic [WORD_WIDTH-1:0] enc_out,
  input  logic [1:0]            enc_last_valid_byte,
  input  logic                  enc_idle,
  output logic                  enc_read_success,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  byte_count,
  output logic                  ser_idle
);

  ack_state_e            state_q, state_d;
  logic                  h_valid;
  logic [WORD_WIDTH-1:0] h_data;
  logic [1:0]            h_lvb;
  logic                  capture, move, move_final;
  logic                  o_empty;
  logic [NBYTES_W-1:0]   move_nbytes;

  // A held word resolves only in A_IDLE; another resultReady wins over enc_idle.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    move       = 1'b0;
    move_final = 1'b0;
    unique case (state_q)
      A_IDLE: begin
        if (h_valid) begin
          if (o_empty && enc_result_ready) begin
            move = 1'b1;
          end else if (o_empty && enc_idle) begin
            move       = 1'b1;
            move_final = 1'b1;
          end
        end else if (enc_result_ready) begin
          capture = 1'b1;
          state_d = A_ACK;
        end
      end
      A_ACK: begin
        if (!enc_result_ready) state_d = A_REL;
      end
      A_REL:   state_d = A_IDLE;
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= A_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_valid <= 1'b0;
      h_data  <= '0;
      h_lvb   <= '0;
    end else if (capture) begin
      h_valid <= 1'b1;
      h_data  <= enc_out;
      h_lvb   <= enc_last_valid_byte;
    end else if (move) begin
      h_valid <= 1'b0;
    end
  end

  assign enc_read_success = (state_q == A_ACK);
  assign ser_idle         = ~h_valid & o_empty & (state_q == A_IDLE);
  assign move_nbytes      = move_final ? (NBYTES_W'(h_lvb) + NBYTES_W'(1))
                                       : NBYTES_W'(WORD_BYTES);

  arith_byte_unpacker #(
    .WORD_WIDTH (WORD_WIDTH),
    .BIT_REVERSE(BIT_REVERSE),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_unpacker (
    .clk        (clk),
    .rstn       (rstn),
    .load       (move),
    .load_data  (h_data),
    .load_nbytes(move_nbytes),
    .load_last  (move_final),
    .empty      (o_empty),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .byte_count (byte_count)
  );

endmodule
